frame_transmit: RTL and testbench
=================================

FRAME_TRANSMIT -- requirements
Module: frame_transmit

Interface
REQ-001 clk  input  1  rising-edge clock; one clock domain only.
REQ-002 reset  input  1  asynchronous, active-high reset.
REQ-003 baudrate  input  8  clocks per line bit; 0 treated as 1.
REQ-004 start  input  1  frame request, sampled only while busy=0.
REQ-005 framesize  input  4  data-byte count N (0..15), captured with start.
REQ-006 datain  input  8  next data byte, transferred when data_valid and data_ready are both 1.
REQ-007 data_valid  input  1  datain holds a byte.
REQ-008 data_ready  output  1  one-byte holding register empty and bytes still to fetch.
REQ-009 TX  output  1  serial line; idle level 0.
REQ-010 busy  output  1  frame in progress.
REQ-011 done  output  1  one-cycle pulse after the stop bit ends.
REQ-012 underrun  output  1  sticky: a data byte was sent as 0x00 because the holding register was empty; cleared on accepted start.

Function
REQ-013 Frame order SHALL be: start bit (1), framesize[3:0] MSB first, N bytes MSB first, CRC[7:0] MSB first, stop bit (0).
REQ-014 Each line bit SHALL be held for exactly max(baudrate,1) clocks by an internal bit timer; baudrate is sampled at accepted start and held for the whole frame.
REQ-015 Accepted start in cycle t SHALL drive busy=1 and TX=1 from cycle t+1.
REQ-016 States SHALL be IDLE -> START -> SIZE -> DATA (skipped when N=0) -> CRC -> STOP -> IDLE, advancing only when the bit timer expires on the field's last bit.
REQ-017 CRC SHALL be CRC-8, polynomial 0x07, initial 0x00, no reflection, no final XOR, computed serially over size and data bits only (never start, stop or stuff bits).
REQ-018 data_ready SHALL be 1 only while busy=1, holding register empty and fetched bytes < N.
REQ-019 At each data-byte boundary the holding register SHALL move into the shift register and empty in the same cycle; if empty, 0x00 is shifted and underrun is set.
REQ-020 After the stop bit's last clock: done=1 for one cycle, busy=0, TX=0 in that same cycle.
REQ-021 start while busy=1 SHALL be ignored; a new start may be accepted in the done cycle.
REQ-022 data_valid while data_ready=0 SHALL be ignored.

Reset
REQ-023 reset SHALL immediately force IDLE, TX=0, busy=0, done=0, data_ready=0, underrun=0, holding register empty, CRC cleared, timers zero, including mid-frame.

Configuration
REQ-024 With FRAME_TX_STUFF_EN defined, after 5 consecutive equal bits in the size, data or CRC fields a complement bit SHALL be inserted; the stuff bit counts as the first bit of the next run, and run tracking starts at the first size bit.
REQ-025 Without FRAME_TX_STUFF_EN, no stuff bits SHALL be inserted and the stuffing logic SHALL be absent.

Structure
REQ-026 Package frame_pkg SHALL hold the state enum, CRC_POLY=8'h07, CRC_INIT=8'h00, STUFF_RUN=5, START_BIT=1'b1 and STOP_BIT=1'b0, and SHALL be shared with the receiver.
REQ-027 CRC SHALL be computed by the existing crc sub-module, with enable pulsed once per non-stuff size/data bit and reset on accepted start.

Verification
REQ-028 Stuffing off, baudrate=2, N=0: TX=1 for 2 clocks, then 0 for 26 clocks; done pulses at cycle t+29; busy high for 28 cycles.
REQ-029 Stuffing off, baudrate=1, N=1, datain=0xFF preloaded: TX = 1,0001,11111111,11100110,0 (CRC 0xE6); underrun=0.
REQ-030 Stuffing on, baudrate=1, N=0: TX = 1, 00000 1 00000 1 00, 0 (16 bits, 2 stuff bits).
REQ-031 N=2, data_valid low throughout: data_ready stays 1, both bytes sent as 0x00, underrun=1 until next accepted start.
REQ-032 reset asserted mid DATA field: TX=0, busy=0 without waiting for a clock edge; a following start sends a complete, correct frame.
REQ-033 start pulsed while busy, and again in the done cycle: the first is ignored; the second begins a new frame with TX=1 in the next cycle.

Source files
------------

// File: rtl/frame_pkg.sv
// Shared frame definitions for the frame transmitter and receiver:
// state encoding, CRC-8 parameters, stuffing run length and line levels.
package frame_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        SIZE,
        DATA,
        CRC,
        STOP
    } state_t;

    localparam logic [7:0]  CRC_POLY  = 8'h07;
    localparam logic [7:0]  CRC_INIT  = 8'h00;
    localparam int unsigned STUFF_RUN = 5;
    localparam logic        START_BIT = 1'b1;
    localparam logic        STOP_BIT  = 1'b0;

    // One serial CRC-8 step, MSB-first, no reflection.
    function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic din);
        logic fb;
        fb = crc[7] ^ din;
        return {crc[6:0], 1'b0} ^ (fb ? CRC_POLY : 8'h00);
    endfunction

endpackage

// File: rtl/frame_transmit_crc.sv
// Serial CRC-8 accumulator: cleared at frame start, one step per enable pulse.
module frame_transmit_crc
    import frame_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       clear,
    input  logic       enable,
    input  logic       din,
    output logic [7:0] crc
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            crc <= CRC_INIT;
        end else if (clear) begin
            crc <= CRC_INIT;
        end else if (enable) begin
            crc <= crc8_step(crc, din);
        end
    end

endmodule

// File: rtl/frame_transmit.sv
// Serial frame transmitter: start, 4-bit size, N data bytes, CRC-8, stop.
// Define FRAME_TX_STUFF_EN to insert a complement bit after 5 equal line bits.
module frame_transmit
    import frame_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] baudrate,
    input  logic       start,
    input  logic [3:0] framesize,
    input  logic [7:0] datain,
    input  logic       data_valid,
    output logic       data_ready,
    output logic       TX,
    output logic       busy,
    output logic       done,
    output logic       underrun
);

    state_t     state, state_next;
    logic [7:0] baud_q, timer;
    logic [2:0] bit_cnt;
    logic [3:0] byte_cnt, n_bytes, fetch_cnt;
    logic [3:0] size_sr;
    logic [7:0] data_sr, hold_data;
    logic       hold_full;
    logic [7:0] crc;
    logic       tick, accept, bit_end, advance, insert, load_byte;
    logic       field_bit, in_field, stuff_active, stuff_bit;

    assign tick   = (timer == baud_q - 8'd1);
    assign accept = start && (state == IDLE);

    always_comb begin
        field_bit = 1'b0;
        case (state)
            SIZE:    field_bit = size_sr[3];
            DATA:    field_bit = data_sr[7];
            CRC:     field_bit = crc[3'd7 - bit_cnt];
            default: field_bit = 1'b0;
        endcase
    end

    assign in_field = (state == SIZE) || (state == DATA) || (state == CRC);

    // A stuff bit keeps the field position frozen; the field advances when it ends.
    assign bit_end = tick && !stuff_active;
    assign advance = (bit_end && !insert) || (tick && stuff_active);

`ifdef FRAME_TX_STUFF_EN
    logic       run_bit;
    logic [2:0] run_cnt, run_cnt_next;

    always_comb begin
        run_cnt_next = 3'd1;
        if (run_cnt != 3'd0 && field_bit == run_bit) begin
            run_cnt_next = run_cnt + 3'd1;
        end
    end

    assign insert    = bit_end && in_field && (run_cnt_next == 3'(STUFF_RUN));
    assign stuff_bit = ~run_bit;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stuff_active <= 1'b0;
            run_bit      <= 1'b0;
            run_cnt      <= '0;
        end else if (accept) begin
            stuff_active <= 1'b0;
            run_bit      <= 1'b0;
            run_cnt      <= '0;
        end else if (tick && stuff_active) begin
            stuff_active <= 1'b0;
            run_bit      <= ~run_bit;
            run_cnt      <= 3'd1;
        end else if (bit_end && in_field) begin
            run_bit      <= field_bit;
            run_cnt      <= run_cnt_next;
            stuff_active <= insert;
        end
    end
`else
    assign insert       = 1'b0;
    assign stuff_active = 1'b0;
    assign stuff_bit    = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = START;
            START:   if (advance) state_next = SIZE;
            SIZE:    if (advance && bit_cnt == 3'd3) state_next = (n_bytes == 4'd0) ? CRC : DATA;
            DATA:    if (advance && bit_cnt == 3'd7 && byte_cnt == n_bytes - 4'd1) state_next = CRC;
            CRC:     if (advance && bit_cnt == 3'd7) state_next = STOP;
            STOP:    if (advance) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy       = (state != IDLE);
        data_ready = busy && !hold_full && (fetch_cnt < n_bytes);
        TX         = 1'b0;
        case (state)
            START:          TX = START_BIT;
            SIZE, DATA, CRC: TX = field_bit;
            STOP:           TX = STOP_BIT;
            default:        TX = 1'b0;
        endcase
        if (stuff_active) begin
            TX = stuff_bit;
        end
    end

    assign load_byte = advance &&
        ((state == SIZE && bit_cnt == 3'd3 && n_bytes != 4'd0) ||
         (state == DATA && bit_cnt == 3'd7 && byte_cnt != n_bytes - 4'd1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            done      <= 1'b0;
            underrun  <= 1'b0;
            baud_q    <= 8'd1;
            timer     <= '0;
            bit_cnt   <= '0;
            byte_cnt  <= '0;
            n_bytes   <= '0;
            fetch_cnt <= '0;
            size_sr   <= '0;
            data_sr   <= '0;
            hold_data <= '0;
            hold_full <= 1'b0;
        end else begin
            done <= (state == STOP) && advance;
            if (accept) begin
                baud_q    <= (baudrate == 8'd0) ? 8'd1 : baudrate;
                n_bytes   <= framesize;
                size_sr   <= framesize;
                timer     <= '0;
                bit_cnt   <= '0;
                byte_cnt  <= '0;
                fetch_cnt <= '0;
                hold_full <= 1'b0;
                underrun  <= 1'b0;
            end else if (busy) begin
                timer <= tick ? 8'd0 : timer + 8'd1;
                if (advance) begin
                    case (state)
                        SIZE: begin
                            size_sr <= {size_sr[2:0], 1'b0};
                            bit_cnt <= (bit_cnt == 3'd3) ? 3'd0 : bit_cnt + 3'd1;
                        end
                        DATA: begin
                            data_sr <= {data_sr[6:0], 1'b0};
                            bit_cnt <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7) byte_cnt <= byte_cnt + 4'd1;
                        end
                        CRC:     bit_cnt <= bit_cnt + 3'd1;
                        default: bit_cnt <= '0;
                    endcase
                end
                if (load_byte) begin
                    data_sr   <= hold_full ? hold_data : 8'h00;
                    hold_full <= 1'b0;
                    if (!hold_full) underrun <= 1'b1;
                end
                // Fetch after the byte-boundary load so an empty register refills in the same cycle.
                if (data_valid && data_ready) begin
                    hold_data <= datain;
                    hold_full <= 1'b1;
                    fetch_cnt <= fetch_cnt + 4'd1;
                end
            end
        end
    end

    frame_transmit_crc u_crc (
        .clk    (clk),
        .reset  (reset),
        .clear  (accept),
        .enable (bit_end && (state == SIZE || state == DATA)),
        .din    (field_bit),
        .crc    (crc)
    );

endmodule

// File: tb/tb_frame_transmit.sv
// Directed self-checking bench for frame_transmit: frame bit patterns, data
// handshake, underrun, asynchronous reset and start handling around busy/done.
module tb_frame_transmit;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] baudrate;
    logic       start;
    logic [3:0] framesize;
    logic [7:0] datain;
    logic       data_valid;
    logic       data_ready, TX, busy, done, underrun;

    int checks   = 0;
    int failures = 0;

`ifdef FRAME_TX_STUFF_EN
    localparam int          EMPTY_BITS = 16;
    localparam logic [63:0] EMPTY_EXP  = 64'({1'b1, 5'b0, 1'b1, 5'b0, 1'b1, 2'b0, 1'b0});
`else
    localparam int          EMPTY_BITS = 14;
    localparam logic [63:0] EMPTY_EXP  = 64'({1'b1, 4'b0000, 8'h00, 1'b0});
`endif

    frame_transmit dut (
        .clk        (clk),
        .reset      (reset),
        .baudrate   (baudrate),
        .start      (start),
        .framesize  (framesize),
        .datain     (datain),
        .data_valid (data_valid),
        .data_ready (data_ready),
        .TX         (TX),
        .busy       (busy),
        .done       (done),
        .underrun   (underrun)
    );

    always #5 clk = ~clk;

    task automatic run_frame(input string name, input logic [7:0] baud, input logic [3:0] size,
                             input int nbits, input logic [63:0] exp, input int glitch_cyc,
                             output int ready_cycles);
        int eff, line_err, busy_err;
        logic [63:0] got;
        eff = (baud == 8'd0) ? 1 : int'(baud);
        got = '0;
        line_err = 0;
        busy_err = 0;
        ready_cycles = 0;
        @(negedge clk);
        baudrate  = baud;
        framesize = size;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int b = 0; b < nbits; b++) begin
            for (int c = 0; c < eff; c++) begin
                if (c == 0) got[nbits-1-b] = TX;
                if (TX !== exp[nbits-1-b]) line_err++;
                if (busy !== 1'b1) busy_err++;
                if (data_ready === 1'b1) ready_cycles++;
                if (b * eff + c == glitch_cyc) begin
                    start     = 1'b1;
                    framesize = 4'hF;
                    baudrate  = 8'd7;
                end else begin
                    start = 1'b0;
                end
                @(negedge clk);
            end
        end
        start = 1'b0;
        checks++;
        if (line_err != 0) begin
            failures++;
            $display("FAIL %s line_bits: got %h expected %h (%0d bad cycles)", name, got, exp, line_err);
        end
        checks++;
        if (busy_err != 0) begin
            failures++;
            $display("FAIL %s busy_during_frame: %0d cycles busy!=1, expected 0", name, busy_err);
        end
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || TX !== 1'b0) begin
            failures++;
            $display("FAIL %s done_cycle: done=%b busy=%b TX=%b expected done=1 busy=0 TX=0", name, done, busy, TX);
        end
    endtask

    task automatic test_reset;
        reset      = 1'b1;
        start      = 1'b0;
        baudrate   = 8'd1;
        framesize  = 4'd0;
        datain     = 8'h00;
        data_valid = 1'b0;
        #12;
        checks++;
        if ({TX, busy, done, data_ready, underrun} !== 5'b0) begin
            failures++;
            $display("FAIL reset_state: TX/busy/done/ready/underrun=%b expected 00000",
                     {TX, busy, done, data_ready, underrun});
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_empty_frame;
        int rc;
        data_valid = 1'b0;
        run_frame("empty_b2", 8'd2, 4'd0, EMPTY_BITS, EMPTY_EXP, -1, rc);
        @(negedge clk);
        checks++;
        if (done !== 1'b0) begin
            failures++;
            $display("FAIL empty_b2 done_pulse_width: done=%b one cycle later, expected 0", done);
        end
        checks++;
        if (rc != 0) begin
            failures++;
            $display("FAIL empty_b2 data_ready: %0d ready cycles, expected 0", rc);
        end
    endtask

`ifndef FRAME_TX_STUFF_EN
    task automatic test_single_byte;
        int rc;
        datain     = 8'hFF;
        data_valid = 1'b1;
        run_frame("one_ff", 8'd1, 4'd1, 22, 64'({1'b1, 4'b0001, 8'hFF, 8'hE6, 1'b0}), -1, rc);
        checks++;
        if (rc != 1) begin
            failures++;
            $display("FAIL one_ff ready_cycles: got %0d expected 1", rc);
        end
        checks++;
        if (underrun !== 1'b0) begin
            failures++;
            $display("FAIL one_ff underrun: got %b expected 0", underrun);
        end
        data_valid = 1'b0;
    endtask

    task automatic test_two_bytes_fed;
        int rc;
        datain     = 8'h00;
        data_valid = 1'b1;
        run_frame("two_fed_b3", 8'd3, 4'd2, 30, 64'({1'b1, 4'b0010, 16'h0000, 8'hD6, 1'b0}), -1, rc);
        checks++;
        if (rc != 2) begin
            failures++;
            $display("FAIL two_fed_b3 ready_cycles: got %0d expected 2", rc);
        end
        checks++;
        if (underrun !== 1'b0) begin
            failures++;
            $display("FAIL two_fed_b3 underrun: got %b expected 0", underrun);
        end
        data_valid = 1'b0;
    endtask

    task automatic test_underrun;
        int rc;
        data_valid = 1'b0;
        run_frame("underrun_b0", 8'd0, 4'd2, 30, 64'({1'b1, 4'b0010, 16'h0000, 8'hD6, 1'b0}), -1, rc);
        checks++;
        if (rc != 30) begin
            failures++;
            $display("FAIL underrun_b0 ready_cycles: got %0d expected 30", rc);
        end
        repeat (4) @(negedge clk);
        checks++;
        if (underrun !== 1'b1) begin
            failures++;
            $display("FAIL underrun_b0 sticky: got %b expected 1", underrun);
        end
    endtask

    task automatic test_back_to_back;
        int rc;
        bit seen;
        datain     = 8'hFF;
        data_valid = 1'b1;
        run_frame("busy_start", 8'd1, 4'd1, 22, 64'({1'b1, 4'b0001, 8'hFF, 8'hE6, 1'b0}), 6, rc);
        baudrate   = 8'd1;
        framesize  = 4'd0;
        start      = 1'b1;
        data_valid = 1'b0;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (TX !== 1'b1 || busy !== 1'b1) begin
            failures++;
            $display("FAIL restart_in_done: TX=%b busy=%b expected TX=1 busy=1", TX, busy);
        end
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (done === 1'b1) seen = 1'b1;
        end
        checks++;
        if (!seen) begin
            failures++;
            $display("FAIL restart_done_timeout: done not seen within 40 cycles, expected pulse");
        end
    endtask
`else
    task automatic test_stuffing;
        int rc;
        data_valid = 1'b0;
        run_frame("stuff_b1", 8'd1, 4'd0, 16, 64'({1'b1, 5'b0, 1'b1, 5'b0, 1'b1, 2'b0, 1'b0}), -1, rc);
    endtask
`endif

    task automatic test_reset_mid_frame;
        int rc;
        data_valid = 1'b0;
        @(negedge clk);
        baudrate  = 8'd3;
        framesize = 4'd2;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (20) @(negedge clk);
        checks++;
        if (busy !== 1'b1 || underrun !== 1'b1) begin
            failures++;
            $display("FAIL pre_reset_state: busy=%b underrun=%b expected busy=1 underrun=1", busy, underrun);
        end
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if ({TX, busy, done, data_ready, underrun} !== 5'b0) begin
            failures++;
            $display("FAIL async_reset: TX/busy/done/ready/underrun=%b expected 00000",
                     {TX, busy, done, data_ready, underrun});
        end
        #1;
        reset = 1'b0;
        run_frame("after_reset", 8'd1, 4'd0, EMPTY_BITS, EMPTY_EXP, -1, rc);
    endtask

    initial begin
        test_reset();
        test_empty_frame();
`ifndef FRAME_TX_STUFF_EN
        test_single_byte();
        test_two_bytes_fed();
        test_underrun();
        test_single_byte();
        test_back_to_back();
`else
        test_stuffing();
`endif
        test_reset_mid_frame();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
